uart8_rx_buffer: RTL and testbench

UART8_RX_BUFFER -- requirements
Module: uart8_rx_buffer

---
 rtl/uart8_pkg.sv | 14 +
 rtl/uart8_fifo_mem.sv | 25 ++
 rtl/uart8_rx_buffer.sv | 107 ++++++++++
 tb/tb_uart8_rx_buffer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart8_pkg.sv
// Shared helpers for the Uart8 receive buffer: byte width, address sizing, capture FSM encoding.
// Pure definitions, no logic, so there is no latency and no backpressure here.
package uart8_pkg;

  localparam int BYTE_W = 8;

  localparam logic [0:0] ST_ARMED    = 1'b0;
  localparam logic [0:0] ST_WAIT_LOW = 1'b1;

  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/uart8_fifo_mem.sv
// DEPTH x 8 register array: synchronous write, asynchronous read, 0-cycle read latency.
// It has no flow control; the caller owns pointer and full/empty tracking.
module uart8_fifo_mem
  import uart8_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [BYTE_W-1:0] wr_dat,
  input  logic [AW-1:0]     rd_addr,
  output logic [BYTE_W-1:0] rd_dat
);

  logic [BYTE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_dat;
  end

  assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/uart8_rx_buffer.sv
// Uart8 receive buffer: one capture per rxDone high period into a show-ahead FIFO; a byte is visible 1 cycle after capture.
// It has no backpressure to the receiver. A full FIFO drops good bytes (sticky overrun), and rxErr bytes only count errors.
module uart8_rx_buffer
  import uart8_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ERR_W = 8
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     rxDone,
  input  logic                     rxErr,
  input  logic [BYTE_W-1:0]        rxByte,
  input  logic                     rdEn,
  input  logic                     clrFlags,
  output logic [BYTE_W-1:0]        rdData,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  output logic [ERR_W-1:0]         errCount
);

  localparam int AW = addr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [0:0]        state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overrun_q, overrun_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              capture, good, bad, pop, push;
  logic [BYTE_W-1:0] mem_rd;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign overrun  = overrun_q;
  assign errCount = err_q;
  // Storage is never reset, so rdData is masked until the head entry is real.
  assign rdData   = empty ? '0 : mem_rd;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARMED: if (rxDone)  state_d = ST_WAIT_LOW;
      default:  if (!rxDone) state_d = ST_ARMED;
    endcase

    capture = (state_q == ST_ARMED) && rxDone;
    good    = capture && !rxErr;
    bad     = capture && rxErr;
    pop     = rdEn && !empty;
    // A same-cycle pop frees the slot, so a full FIFO can still accept.
    push    = good && (!full || pop);

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    overrun_d = overrun_q;
    if (good && !push) overrun_d = 1'b1;
    else if (clrFlags) overrun_d = 1'b0;

    err_d = err_q;
    if (bad)           err_d = (err_q == '1) ? err_q : err_q + ERR_W'(1);
    else if (clrFlags) err_d = '0;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= ST_ARMED;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      err_q     <= err_d;
    end
  end

  uart8_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_dat  (rxByte),
    .rd_addr (rd_ptr_q),
    .rd_dat  (mem_rd)
  );

endmodule

// File: tb/tb_uart8_rx_buffer.sv
// Bench for uart8_rx_buffer: directed scenarios plus randomized traffic checked against a queue model.
module tb_uart8_rx_buffer;

  localparam int DEPTH = 8;
  localparam int ERR_W = 8;
  localparam int CW    = 4;

  logic            clk = 1'b0;
  logic            rstN, rxDone, rxErr, rdEn, clrFlags;
  logic [7:0]      rxByte, rdData;
  logic            empty, full, overrun;
  logic [CW-1:0]   count;
  logic [ERR_W-1:0] errCount;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a byte queue, a sticky flag, an error tally, and the last sampled rxDone level.
  byte unsigned mq[$];
  bit m_ovr;
  int m_err;
  bit m_prev;

  always #5 clk = ~clk;

  uart8_rx_buffer #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clk(clk), .rstN(rstN), .rxDone(rxDone), .rxErr(rxErr), .rxByte(rxByte),
    .rdEn(rdEn), .clrFlags(clrFlags), .rdData(rdData), .empty(empty), .full(full),
    .count(count), .overrun(overrun), .errCount(errCount)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    mq.delete();
    m_ovr = 0;
    m_err = 0;
    m_prev = 0;
  endtask

  // Drives inputs for one clock, advances the model, and returns #1 after the edge.
  task automatic step(input bit d, input bit e, input logic [7:0] b, input bit r, input bit c);
    bit cap, pp, set_ovr;
    rxDone = d; rxErr = e; rxByte = b; rdEn = r; clrFlags = c;
    cap = d && !m_prev;
    pp  = r && (mq.size() > 0);
    if (pp) void'(mq.pop_front());
    set_ovr = 0;
    if (cap && !e) begin
      if (mq.size() < DEPTH) mq.push_back(b);
      else set_ovr = 1;
    end
    if (set_ovr) m_ovr = 1;
    else if (c) m_ovr = 0;
    if (cap && e) begin
      if (m_err < (1 << ERR_W) - 1) m_err++;
    end else if (c) m_err = 0;
    m_prev = d;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] b, input bit e, input int hi);
    for (int i = 0; i < hi; i++) step(1, e, b, 0, 0);
    step(0, 0, b, 0, 0);
  endtask

  task automatic do_reset();
    rstN = 0; rxDone = 0; rxErr = 0; rxByte = 0; rdEn = 0; clrFlags = 0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rstN = 1;
  endtask

  task automatic test_reset();
    rstN = 0; rxDone = 0; rxErr = 0; rxByte = 8'h77; rdEn = 0; clrFlags = 0;
    model_reset();
    #2;
    vectors++;
    if (count !== 0 || empty !== 1'b1 || full !== 1'b0 || overrun !== 1'b0 ||
        errCount !== 0 || rdData !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state: got count=%0d empty=%b full=%b ovr=%b err=%0d rd=%0d want 0 1 0 0 0 0",
               count, empty, full, overrun, errCount, rdData);
    end
    @(posedge clk);
    #1;
    rstN = 1;
  endtask

  task automatic test_two_bytes();
    do_reset();
    step(1, 0, 8'd30, 0, 0);
    vectors++;
    if (empty !== 1'b0 || rdData !== 8'd30) begin
      miscompares++;
      $display("FAIL latency1: got empty=%b rdData=%0d want 0 30", empty, rdData);
    end
    for (int i = 0; i < 4; i++) step(1, 0, 8'd30, 0, 0);
    step(0, 0, 8'd30, 0, 0);
    vectors++;
    if (count !== 1) begin
      miscompares++;
      $display("FAIL single_capture: got count=%0d want 1", count);
    end
    feed(8'd24, 0, 5);
    vectors++;
    if (count !== 2 || rdData !== 8'd30) begin
      miscompares++;
      $display("FAIL two_bytes: got count=%0d rdData=%0d want 2 30", count, rdData);
    end
    step(0, 0, 8'd0, 1, 0);
    vectors++;
    if (count !== 1 || rdData !== 8'd24) begin
      miscompares++;
      $display("FAIL pop_next: got count=%0d rdData=%0d want 1 24", count, rdData);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int i = 0; i < 9; i++) feed(8'(i), 0, 2);
    vectors++;
    if (full !== 1'b1 || overrun !== 1'b1 || count !== 8) begin
      miscompares++;
      $display("FAIL overrun_full: got full=%b ovr=%b count=%0d want 1 1 8", full, overrun, count);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (rdData !== 8'(i)) begin
        miscompares++;
        $display("FAIL overrun_order: got %0d want %0d", rdData, i);
      end
      step(0, 0, 8'd0, 1, 0);
    end
    step(0, 0, 8'd0, 1, 0);
    vectors++;
    if (empty !== 1'b1 || count !== 0 || overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL pop_empty: got empty=%b count=%0d ovr=%b want 1 0 1", empty, count, overrun);
    end
    step(0, 0, 8'd0, 0, 1);
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_overrun: got %b want 0", overrun);
    end
  endtask

  task automatic test_errors();
    do_reset();
    for (int i = 0; i < 3; i++) feed(8'hAA, 1, 3);
    vectors++;
    if (count !== 0 || errCount !== 3) begin
      miscompares++;
      $display("FAIL err_count: got count=%0d err=%0d want 0 3", count, errCount);
    end
    step(0, 0, 8'd0, 0, 1);
    vectors++;
    if (errCount !== 0) begin
      miscompares++;
      $display("FAIL err_clear: got %0d want 0", errCount);
    end
    for (int i = 0; i < 300; i++) feed(8'(i), 1, 1);
    vectors++;
    if (errCount !== 8'hFF || count !== 0) begin
      miscompares++;
      $display("FAIL err_saturate: got err=%0d count=%0d want 255 0", errCount, count);
    end
    step(0, 0, 8'd0, 0, 1);
    vectors++;
    if (errCount !== 0) begin
      miscompares++;
      $display("FAIL err_clear_sat: got %0d want 0", errCount);
    end
  endtask

  task automatic test_full_pop();
    byte unsigned exp_q[$];
    do_reset();
    for (int i = 0; i < 8; i++) feed(8'(8'h10 + i), 0, 2);
    step(1, 0, 8'd255, 1, 0);
    vectors++;
    if (count !== 8 || overrun !== 1'b0 || full !== 1'b1) begin
      miscompares++;
      $display("FAIL full_pop: got count=%0d ovr=%b full=%b want 8 0 1", count, overrun, full);
    end
    step(0, 0, 8'd0, 0, 0);
    for (int i = 1; i < 8; i++) exp_q.push_back(8'(8'h10 + i));
    exp_q.push_back(8'd255);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (rdData !== exp_q[i]) begin
        miscompares++;
        $display("FAIL full_pop_order: slot %0d got %0d want %0d", i, rdData, exp_q[i]);
      end
      step(0, 0, 8'd0, 1, 0);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    for (int i = 0; i < 4; i++) feed(8'(8'h40 + i), 0, 2);
    rxDone = 1; rxByte = 8'h5C; rstN = 0;
    #2;
    vectors++;
    if (empty !== 1'b1 || count !== 0) begin
      miscompares++;
      $display("FAIL async_reset: got empty=%b count=%0d want 1 0", empty, count);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rstN = 1;
    model_reset();
    vectors++;
    if (empty !== 1'b1) begin
      miscompares++;
      $display("FAIL post_release: got empty=%b want 1", empty);
    end
    step(1, 0, 8'h5C, 0, 0);
    vectors++;
    if (count !== 1 || rdData !== 8'h5C) begin
      miscompares++;
      $display("FAIL recapture: got count=%0d rdData=%0d want 1 92", count, rdData);
    end
    step(0, 0, 8'h00, 0, 0);
  endtask

  task automatic test_random();
    bit d;
    int rd_mod;
    do_reset();
    d = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0) d = ~d;
      rd_mod = (n < 1500) ? 6 : 2;
      step(d, ($urandom_range(0, 7) == 0), 8'($urandom), ($urandom_range(0, rd_mod - 1) == 0),
           ($urandom_range(0, 39) == 0));
      vectors++;
      if (count !== CW'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH) ||
          overrun !== m_ovr || errCount !== ERR_W'(m_err) ||
          (mq.size() > 0 && rdData !== mq[0])) begin
        miscompares++;
        $display("FAIL random[%0d]: got count=%0d empty=%b full=%b ovr=%b err=%0d rd=%0d want count=%0d ovr=%b err=%0d rd=%0d",
                 n, count, empty, full, overrun, errCount, rdData, mq.size(), m_ovr, m_err,
                 (mq.size() > 0) ? mq[0] : 0);
      end
    end
  endtask

  task automatic test_loopback();
    byte unsigned sent[20] = '{30, 24, 7, 99, 200, 1, 128, 64, 255, 0, 17, 42, 73, 180, 3, 90, 111, 250, 5, 2};
    byte unsigned got[$];
    int guard;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 4; k++) step(1, 0, sent[i], 0, 0);
      for (int k = 0; k < 3; k++) begin
        if (!empty) got.push_back(rdData);
        step(0, 0, sent[i], 1, 0);
      end
    end
    guard = 0;
    while (!empty && guard < 16) begin
      got.push_back(rdData);
      step(0, 0, 8'd0, 1, 0);
      guard++;
    end
    vectors++;
    if (got.size() != 20) begin
      miscompares++;
      $display("FAIL loop_count: got %0d bytes want 20", got.size());
    end
    for (int i = 0; i < 20 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== sent[i]) begin
        miscompares++;
        $display("FAIL loop_data[%0d]: got %0d want %0d", i, got[i], sent[i]);
      end
    end
    vectors++;
    if (errCount !== 0 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL loop_flags: got err=%0d ovr=%b want 0 0", errCount, overrun);
    end
  endtask

  initial begin
    test_reset();
    test_two_bytes();
    test_overrun();
    test_errors();
    test_full_pop();
    test_reset_midframe();
    test_random();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
